// File: rtl/reg_file_pkg.sv
// Shared constants for the register file: default geometry, configuration-word
// addresses and their reset values. Optional macro: REGFILE_CFG_DEFAULTS_EN.
package reg_file_pkg;

    localparam int DEF_BUS_WIDTH  = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_ADDR_WIDTH = 4;

    // Configuration words consumed by neighbouring blocks (ALU operands, UART config).
    localparam int REG0_ADDR = 0;
    localparam int REG1_ADDR = 1;
    localparam int REG2_ADDR = 2;
    localparam int REG3_ADDR = 3;

    // REG2: parity enabled, even parity. REG3: prescale 32.
    localparam logic [7:0] REG2_RST_VAL = 8'b1000_0001;
    localparam logic [7:0] REG3_RST_VAL = 8'b0010_0000;

`ifdef REGFILE_CFG_DEFAULTS_EN
    localparam bit CFG_DEFAULTS_EN = 1'b1;
`else
    localparam bit CFG_DEFAULTS_EN = 1'b0;
`endif

endpackage

// File: rtl/reg_file.sv
// Register file with one shared address bus, a registered read port and
// continuous views of words 0..3. Optional macro: REGFILE_CFG_DEFAULTS_EN.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [BUS_WIDTH-1:0]  WrData,
    output logic [BUS_WIDTH-1:0]  REG0,
    output logic [BUS_WIDTH-1:0]  REG1,
    output logic [BUS_WIDTH-1:0]  REG2,
    output logic [BUS_WIDTH-1:0]  REG3,
    output logic [BUS_WIDTH-1:0]  RdData,
    output logic                  RdData_Valid
);

    localparam int                  IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic [BUS_WIDTH-1:0] MEM [DEPTH];

    logic             w_wr;
    logic             w_rd;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;

    // Handshake: RdData_Valid is a one-cycle strobe, high in the cycle after a
    // read was accepted, with RdData valid alongside it. There is no backpressure.
    assign w_wr       = WrEn & ~RdEn;
    assign w_rd       = RdEn & ~WrEn;
    assign w_in_range = {1'b0, Address} < DEPTH_LIM;
    assign w_idx      = Address[IDX_W-1:0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                MEM[i] <= '0;
            end
            MEM[REG2_ADDR] <= CFG_DEFAULTS_EN ? BUS_WIDTH'(REG2_RST_VAL) : '0;
            MEM[REG3_ADDR] <= CFG_DEFAULTS_EN ? BUS_WIDTH'(REG3_RST_VAL) : '0;
            RdData         <= '0;
            RdData_Valid   <= 1'b0;
        end else begin
            RdData_Valid <= w_rd;
            if (w_wr && w_in_range) begin
                MEM[w_idx] <= WrData;
            end
            // Out-of-range reads still complete, returning zero.
            if (w_rd) begin
                RdData <= w_in_range ? MEM[w_idx] : '0;
            end
        end
    end

    assign REG0 = MEM[REG0_ADDR];
    assign REG1 = MEM[REG1_ADDR];
    assign REG2 = MEM[REG2_ADDR];
    assign REG3 = MEM[REG3_ADDR];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file (BUS_WIDTH=16, DEPTH=8, ADDR_WIDTH=4), honouring
// REGFILE_CFG_DEFAULTS_EN when it is defined.
module tb_reg_file;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 4;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
        logic          exp_valid;
        logic          chk_data;
        logic [W-1:0]  exp_rdata;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  reg0, reg1, reg2, reg3;
    logic [W-1:0]  rd_data;
    logic          rd_valid;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] model [D];
    logic [W-1:0] exp_q [$];
    vec_t         vecs  [$];
    logic [W-1:0] rst2, rst3;

    reg_file #(.BUS_WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) DUT (
        .CLK          (clk),
        .RST          (rst_n),
        .WrEn         (wr_en),
        .RdEn         (rd_en),
        .Address      (addr),
        .WrData       (wr_data),
        .REG0         (reg0),
        .REG1         (reg1),
        .REG2         (reg2),
        .REG3         (reg3),
        .RdData       (rd_data),
        .RdData_Valid (rd_valid)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: present one operation and let exactly one rising edge consume it.
    task automatic drive(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        wr_en   = wr;
        rd_en   = rd;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
        if (wr && !rd && a < D) model[a] = d;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < D; i++) chk($sformatf("%s_mem%0d", tag, i), DUT.MEM[i], model[i]);
    endtask

    task automatic add_vec(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [W-1:0] d,
                           input logic ev, input logic cd, input logic [W-1:0] er);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d;
        v.exp_valid = ev; v.chk_data = cd; v.exp_rdata = er;
        vecs.push_back(v);
    endtask

    initial begin
        logic [W-1:0] dat [D];
        dat = '{16'h00A5, 16'h5A3C, 16'hFFFF, 16'h8001, 16'h0F0F, 16'hC3C3, 16'h7E7E, 16'h0001};

`ifdef REGFILE_CFG_DEFAULTS_EN
        rst2 = 16'h0081;
        rst3 = 16'h0020;
`else
        rst2 = 16'h0000;
        rst3 = 16'h0000;
`endif

        // Writes 0..7, out-of-range write, reads (continuous), idle hold,
        // illegal both-high, read-after-write.
        for (int i = 0; i < D; i++) add_vec(1, 0, AW'(i), dat[i], 0, 0, '0);
        add_vec(1, 0, 4'd9, 16'h1234, 0, 0, '0);
        add_vec(0, 1, 4'd9, 16'h0000, 1, 1, 16'h0000);
        for (int i = 0; i < D; i++) add_vec(0, 1, AW'(i), 16'h0000, 1, 1, dat[i]);
        add_vec(0, 0, 4'd2, 16'hDEAD, 0, 1, dat[7]);
        add_vec(1, 1, 4'd5, 16'hFFFF, 0, 1, dat[7]);
        add_vec(0, 1, 4'd5, 16'h0000, 1, 1, dat[5]);
        add_vec(1, 0, 4'd4, 16'hBEEF, 0, 0, '0);
        add_vec(0, 1, 4'd4, 16'h0000, 1, 1, 16'hBEEF);

        for (int i = 0; i < D; i++) model[i] = '0;
        model[2] = rst2;
        model[3] = rst3;

        // Reset state
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_mem("reset");
        chk("reset_rdata", rd_data, '0);
        chk("reset_valid", {15'd0, rd_valid}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Both enables high: nothing happens
        drive(1, 1, 4'd0, 16'hA1B2);
        chk("both_mem0", DUT.MEM[0], 16'h0000);
        chk("both_valid", {15'd0, rd_valid}, 16'd0);

        // Both enables low: idle
        drive(0, 0, 4'd1, 16'hB1A2);
        chk("idle_mem1", DUT.MEM[1], 16'h0000);
        chk("idle_valid", {15'd0, rd_valid}, 16'd0);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_valid", i), {15'd0, rd_valid}, {15'd0, vecs[i].exp_valid});
            if (vecs[i].chk_data) chk($sformatf("vec%0d_rdata", i), rd_data, vecs[i].exp_rdata);
        end
        check_mem("after_vec");
        chk("reg0", reg0, model[0]);
        chk("reg1", reg1, model[1]);
        chk("reg2", reg2, model[2]);
        chk("reg3", reg3, model[3]);

        // Random writes then random readback through the expected queue
        for (int i = 0; i < 8; i++) begin
            int a;
            a = $urandom_range(0, D - 1);
            drive(1, 0, AW'(a), W'($urandom_range(0, 65535)));
        end
        check_mem("rand_wr");
        for (int i = 0; i < 8; i++) begin
            int a;
            a = $urandom_range(0, D - 1);
            exp_q.push_back(model[a]);
            drive(0, 1, AW'(a), '0);
            chk($sformatf("rand_rd%0d_valid", i), {15'd0, rd_valid}, 16'd1);
            if (exp_q.size() > 0) chk($sformatf("rand_rd%0d_data", i), rd_data, exp_q.pop_front());
        end

        // Reset asserted mid-read, between clock edges
        drive(0, 1, 4'd3, '0);
        chk("midrst_pre_valid", {15'd0, rd_valid}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {15'd0, rd_valid}, 16'd0);
        chk("midrst_rdata", rd_data, '0);
        chk("midrst_mem2", DUT.MEM[2], rst2);
        chk("midrst_mem3", DUT.MEM[3], rst3);
        for (int i = 0; i < D; i++) model[i] = '0;
        model[2] = rst2;
        model[3] = rst3;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_hold_valid", {15'd0, rd_valid}, 16'd0);
        check_mem("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 4'd2, '0);
        chk("post_rst_valid", {15'd0, rd_valid}, 16'd1);
        chk("post_rst_rdata", rd_data, rst2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
